tdc_sample_averager: RTL
========================

# tdc_sample_averager

Downstream post-processing stage for the TDC in the micro-tile sensor chain. Consumes the 8-bit thermometer code produced by the TDC on each measurement and converts it to a popcount. It accumulates a window of 2^LOG2_N measurements and publishes the sum, mean, min, max and a bubble-error count through a valid/ack handshake. It runs on the system clock, while the TDC's sample strobe arrives from the delayed-clock domain and is synchronized internally.

## Interface

Parameters:
- WIDTH, 8, thermometer code width; CNT_W = clog2(WIDTH+1) (4 at default).
- LOG2_N, 4, log2 of samples per window (16 at default); SUM_W = CNT_W+LOG2_N (8 at default).

Ports:
- clk  in  1  system clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- start_i  in  1  begin a window; level sampled in IDLE only.
- clear_i  in  1  synchronous abort; highest priority after rst_n.
- cont_i  in  1  continuous mode; sampled on the ack edge.
- sample_i  in  1  TDC measurement strobe, asynchronous to clk.
- tdc_code_i  in  WIDTH  TDC thermometer code; LSB-first ones.
- ack_i  in  1  consumer acknowledge of the result.
- valid_o  out  1  result available.
- busy_o  out  1  high in ACCUM.
- sum_o  out  SUM_W  sum of popcounts over the window.
- mean_o  out  CNT_W  sum_o >> LOG2_N (truncated).
- min_o / max_o  out  CNT_W  min/max popcount in the window.
- bubble_cnt_o  out  8  samples in the window whose code had a bubble; saturates at 255.
- overrun_o  out  1  sticky; a sample arrived while in DONE.

## Operation

- **Sample synchronization.** sample_i passes through a 2-flop synchronizer (s1, s2) plus a history flop s3. Sample pulse = s2 & ~s3.
- **Source requirements.** sample_i must be high for at least 2 clk cycles and low for at least 2. tdc_code_i must be stable from 1 cycle before sample_i rises until 4 cycles after. Narrower pulses may be missed; this is not flagged.
- **Popcount.** pop = number of ones in tdc_code_i, over 0..WIDTH.
- **Bubble.** A sample has a bubble if any bit i≥1 is 1 while bit i-1 is 0. A bubbled code is still accumulated by popcount.
- **IDLE.**
  - Sample pulses are ignored.
  - start_i=1 → ACCUM, with sum=0, count=0, min=WIDTH, max=0, bubble_cnt=0, overrun cleared.
- **ACCUM.**
  - busy_o=1; start_i is ignored.
  - On each sample pulse: sum+=pop, min=min(min,pop), max=max(max,pop), bubble_cnt+=bubble (saturating), count+=1.
  - The pulse that completes 2^LOG2_N samples updates all results on the same edge and enters DONE.
  - count is LOG2_N+1 bits. Sum cannot overflow, because SUM_W is sized for the worst case.
- **DONE.**
  - valid_o=1; all result outputs are held stable.
  - A sample pulse does not change the results and sets overrun_o.
  - ack_i=1 with cont_i=0 → IDLE.
  - ack_i=1 with cont_i=1 → ACCUM with accumulators reinitialized, as on start. overrun_o is preserved across a continuous restart and is cleared only by start or clear.
- **clear_i=1, any state.** → IDLE; all accumulators, results and overrun_o return to their reset values on that edge.
- **Output mapping.** min_o/max_o/sum_o/bubble_cnt_o drive the live registers. Consumers may only rely on them while valid_o=1.

## Timing

- **Reset values.** valid_o=0, busy_o=0, sum_o=0, mean_o=0, min_o=0, max_o=0, bubble_cnt_o=0, overrun_o=0, state=IDLE, synchronizer flops=0.
- **Start.** start_i high at edge t → busy_o=1 after t.
- **Sample latency.** sample_i rises before edge k → s1 at k, s2 at k+1, pulse during cycle k+1..k+2, accumulation at edge k+2.
- **Final sample.** For the last sample of the window, valid_o=1 and busy_o=0 after edge k+2.
- **Ack.** ack_i high at edge a in DONE → valid_o=0 after a. With cont_i=1, busy_o=1 after a.
- **Coincident ack and sample.** A sample pulse on the same edge as ack+cont is NOT accumulated and sets overrun_o.
- **Ack outside DONE.** ack_i in IDLE or ACCUM is ignored.
- **Mid-window reset.** Asserting rst_n low mid-window forces reset values immediately, without waiting for clk. No partial result is ever presented.

## Test plan

- **Reset.** Reset asserted mid-ACCUM → all outputs take their reset values asynchronously; after release, state is IDLE and valid_o=0.
- **Uniform window.** start, then 16 samples of 8'h0F → sum_o=64, mean_o=4, min_o=max_o=4, bubble_cnt_o=0. valid_o rises 2 edges after the last synchronized strobe.
- **Mixed window.** 8×8'h03 then 8×8'h7F → sum_o=72, mean_o=4, min_o=2, max_o=7.
- **Bubbles.** 16×8'b0000_1011 → sum_o=48, mean_o=3, bubble_cnt_o=16. Also 16×8'hFF → sum_o=128, mean_o=8.
- **Handshake and overrun.** Extra strobe in DONE → results unchanged and overrun_o=1. ack_i with cont_i=1 → busy_o=1 next cycle and the next window sums from 0. ack_i with cont_i=0 → IDLE.
- **Abort and guards.** clear_i after 5 samples → IDLE with all results 0; a new start plus 16×8'h01 gives sum_o=16. A 1-cycle sample_i pulse and start_i during ACCUM both leave count unaffected.

Source files
------------

// File: rtl/tdc_sample_averager.sv
// tdc_sample_averager
//   Window averager for TDC thermometer codes. It synchronizes the TDC
//   strobe into clk, popcounts each code and flags bubbles. Over a window
//   of 2^LOG2_N samples it accumulates the sum, min, max and bubble count,
//   then presents them through a valid/ack handshake.
// Ports:
//   clk, rst_n       system clock, async active-low reset
//   start_i          begin a window (IDLE only)
//   clear_i          synchronous abort back to IDLE with results zeroed
//   cont_i           on ack, restart a new window instead of going idle
//   sample_i         TDC strobe (async), tdc_code_i thermometer code
//   ack_i            consumer acknowledge while valid_o
//   valid_o, busy_o  result available / window in progress
//   sum_o, mean_o, min_o, max_o, bubble_cnt_o  window results
//   overrun_o        sticky: a strobe arrived while a result was pending
module tdc_sample_averager #(
  parameter  int WIDTH  = 8,
  parameter  int LOG2_N = 4,
  localparam int CNT_W  = $clog2(WIDTH + 1),
  localparam int SUM_W  = CNT_W + LOG2_N
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start_i,
  input  logic             clear_i,
  input  logic             cont_i,
  input  logic             sample_i,
  input  logic [WIDTH-1:0] tdc_code_i,
  input  logic             ack_i,
  output logic             valid_o,
  output logic             busy_o,
  output logic [SUM_W-1:0] sum_o,
  output logic [CNT_W-1:0] mean_o,
  output logic [CNT_W-1:0] min_o,
  output logic [CNT_W-1:0] max_o,
  output logic [7:0]       bubble_cnt_o,
  output logic             overrun_o
);

  typedef enum logic [1:0] {IDLE, ACCUM, DONE} state_t;

  typedef struct packed {
    logic [SUM_W-1:0] sum;
    logic [CNT_W-1:0] mn;
    logic [CNT_W-1:0] mx;
    logic [7:0]       bub;
  } res_t;

  state_t          state;
  res_t            res, res_start, res_upd;
  logic [LOG2_N:0] cnt, cnt_nxt;
  logic            valid, busy, ovr;

  // sync[0]=s1, sync[1]=s2, sync[2]=s3 (history for edge detect)
  logic [2:0] sync;
  logic       pulse;

  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) sync <= '0;
    else        sync <= {sync[1:0], sample_i};

  assign pulse = sync[1] & ~sync[2];

  // popcount and bubble detect on the raw code; the code is held stable
  // by the source across the synchronizer latency
  logic [CNT_W-1:0] pop;
  logic             bubble;

  always_comb begin
    pop = '0;
    for (int i = 0; i < WIDTH; i++) pop = pop + CNT_W'(tdc_code_i[i]);
  end

  // a one above a zero anywhere means the code is not a clean thermometer
  assign bubble = |(tdc_code_i[WIDTH-1:1] & ~tdc_code_i[WIDTH-2:0]);

  always_comb begin
    res_start     = '0;
    res_start.mn  = CNT_W'(WIDTH);
    res_upd       = res;
    res_upd.sum   = res.sum + SUM_W'(pop);
    res_upd.mn    = (pop < res.mn) ? pop : res.mn;
    res_upd.mx    = (pop > res.mx) ? pop : res.mx;
    res_upd.bub   = (bubble && res.bub != 8'hFF) ? res.bub + 8'd1 : res.bub;
  end

  assign cnt_nxt = cnt + (LOG2_N+1)'(1);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      res   <= '0;
      cnt   <= '0;
      valid <= 1'b0;
      busy  <= 1'b0;
      ovr   <= 1'b0;
    end else if (clear_i) begin
      state <= IDLE;
      res   <= '0;
      cnt   <= '0;
      valid <= 1'b0;
      busy  <= 1'b0;
      ovr   <= 1'b0;
    end else begin
      case (state)
        IDLE: if (start_i) begin
          state <= ACCUM;
          res   <= res_start;
          cnt   <= '0;
          busy  <= 1'b1;
          ovr   <= 1'b0;
        end
        ACCUM: if (pulse) begin
          res <= res_upd;
          cnt <= cnt_nxt;
          // top bit set means 2^LOG2_N samples are in
          if (cnt_nxt[LOG2_N]) begin
            state <= DONE;
            busy  <= 1'b0;
            valid <= 1'b1;
          end
        end
        DONE: begin
          // results are frozen here; a strobe, even one coincident with
          // a continuous restart, is dropped and only flagged
          if (pulse) ovr <= 1'b1;
          if (ack_i) begin
            valid <= 1'b0;
            if (cont_i) begin
              state <= ACCUM;
              res   <= res_start;
              cnt   <= '0;
              busy  <= 1'b1;
            end else begin
              state <= IDLE;
            end
          end
        end
        default: begin
          state <= IDLE;
          valid <= 1'b0;
          busy  <= 1'b0;
        end
      endcase
    end
  end

  assign valid_o      = valid;
  assign busy_o       = busy;
  assign sum_o        = res.sum;
  assign mean_o       = res.sum[SUM_W-1:LOG2_N];
  assign min_o        = res.mn;
  assign max_o        = res.mx;
  assign bubble_cnt_o = res.bub;
  assign overrun_o    = ovr;

endmodule
